// File: rtl/light_package.sv
// Shared types for the multiphase traffic-light controller: light colours,
// controller state and the default five-phase intersection layout.
package light_package;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } colors;

    typedef enum logic [1:0] {
        TLC_ALLRED = 2'd0,
        TLC_GREEN  = 2'd1,
        TLC_YELLOW = 2'd2
    } tlc_state_t;

    // Phase 0 in the LSBs: {ns}, {e_left,w_left}, {w_str,w_left}, {e_str,e_left}, {e_str,w_str}
    localparam logic [24:0] DEFAULT_PHASE_MASK = {5'b10000, 5'b01100, 5'b01010, 5'b00101, 5'b00011};

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tlc_multiphase_if.sv
// Sensor/preempt inputs and light/status outputs of the controller.
interface tlc_multiphase_if
    import light_package::*;
#(
    parameter int NUM_LIGHTS = 5,
    parameter int NUM_PHASES = 5
) ();
    localparam int PW = $clog2(NUM_PHASES);

    logic [NUM_LIGHTS-1:0]  sensor;
    logic                   preempt_req;
    logic [PW-1:0]          preempt_phase;
    colors [NUM_LIGHTS-1:0] lights;
    logic [PW-1:0]          cur_phase;
    tlc_state_t             tlc_state;
    logic                   preempt_ack;

    modport master (
        output sensor, preempt_req, preempt_phase,
        input  lights, cur_phase, tlc_state, preempt_ack
    );

    modport slave (
        input  sensor, preempt_req, preempt_phase,
        output lights, cur_phase, tlc_state, preempt_ack
    );
endinterface

// File: rtl/tlc_multiphase_rr_pick.sv
// Combinational round-robin finder: first phase with demand, searching from
// last+1 and wrapping around so that last itself is considered at the end.
module tlc_rr_pick #(
    parameter int NUM_PHASES = 5,
    parameter int PW         = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] dem,
    input  logic [PW-1:0]         last,
    output logic                  found,
    output logic [PW-1:0]         next_phase
);
    logic [PW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found      = 1'b0;
        next_phase = last;
        idx        = '0;
        for (int i = NUM_PHASES; i >= 1; i--) begin
            idx = PW'((int'(last) + i) % NUM_PHASES);
            if (dem[idx]) begin
                found      = 1'b1;
                next_phase = idx;
            end
        end
    end
endmodule

// File: rtl/tlc_multiphase.sv
// N-phase traffic-light controller: mask-defined phases, vacancy/max-green
// timing, fixed yellow, minimum all-red and emergency preemption.
//   state      | meaning
//   TLC_ALLRED | all red; after the minimum, pick preempt phase or next demand
//   TLC_GREEN  | cur_phase lights green; vacancy / max-green / preempt exit
//   TLC_YELLOW | cur_phase lights yellow for a fixed time
module tlc_multiphase
    import light_package::*;
#(
    parameter int NUM_LIGHTS    = 5,
    parameter int NUM_PHASES    = 5,
    parameter logic [NUM_PHASES*NUM_LIGHTS-1:0] PHASE_MASK = DEFAULT_PHASE_MASK,
    parameter int VACANT_CYC    = 5,
    parameter int MAX_GREEN_CYC = 10,
    parameter int YELLOW_CYC    = 2,
    parameter int ALLRED_CYC    = 1
) (
    input  logic             clk,
    input  logic             reset,
    tlc_multiphase_if.slave  bus
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam int CW = $clog2(max4(VACANT_CYC, MAX_GREEN_CYC, YELLOW_CYC, ALLRED_CYC) + 1);

    tlc_state_t             state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [CW-1:0]          vac_q, vac_d, max_q, max_d, tmr_q, tmr_d;
    logic [NUM_PHASES-1:0]  dem, conf;
    logic [NUM_LIGHTS-1:0]  cur_mask;
    logic                   pre_valid, pre_here, found, vac_run, max_run;
    logic [PW-1:0]          pick;
    colors [NUM_LIGHTS-1:0] lights_c;

    always_comb begin
        dem      = '0;
        conf     = '0;
        cur_mask = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            dem[p]  = |(bus.sensor &  PHASE_MASK[p*NUM_LIGHTS +: NUM_LIGHTS]);
            conf[p] = |(bus.sensor & ~PHASE_MASK[p*NUM_LIGHTS +: NUM_LIGHTS]);
            if (phase_q == PW'(p)) cur_mask = PHASE_MASK[p*NUM_LIGHTS +: NUM_LIGHTS];
        end
    end

    assign pre_valid = bus.preempt_req && (int'(bus.preempt_phase) < NUM_PHASES);
    assign pre_here  = pre_valid && (bus.preempt_phase == phase_q);
    assign vac_run   = !dem[phase_q] || (vac_q != '0);
    assign max_run   = conf[phase_q] || (max_q != '0);

    tlc_rr_pick #(.NUM_PHASES(NUM_PHASES), .PW(PW)) u_rr_pick (
        .dem        (dem),
        .last       (phase_q),
        .found      (found),
        .next_phase (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TLC_ALLRED;
            phase_q <= PW'(NUM_PHASES - 1);
            vac_q   <= '0;
            max_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            vac_q   <= vac_d;
            max_q   <= max_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        vac_d   = vac_q;
        max_d   = max_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            TLC_ALLRED: begin
                // Timer saturates at the minimum so a long idle all-red never wraps.
                if (tmr_q == CW'(ALLRED_CYC - 1)) begin
                    if (pre_valid || found) begin
                        state_d = TLC_GREEN;
                        phase_d = pre_valid ? bus.preempt_phase : pick;
                        tmr_d   = '0;
                        vac_d   = '0;
                        max_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            TLC_GREEN: begin
                if (pre_here) begin
                    vac_d = '0;
                    max_d = '0;
                end else if (pre_valid ||
                             (vac_run && vac_q == CW'(VACANT_CYC - 1)) ||
                             (max_run && max_q == CW'(MAX_GREEN_CYC - 1))) begin
                    state_d = TLC_YELLOW;
                    vac_d   = '0;
                    max_d   = '0;
                    tmr_d   = '0;
                end else begin
                    if (vac_run) vac_d = vac_q + 1'b1;
                    if (max_run) max_d = max_q + 1'b1;
                end
            end
            TLC_YELLOW: begin
                if (tmr_q == CW'(YELLOW_CYC - 1)) begin
                    state_d = TLC_ALLRED;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = TLC_ALLRED;
                tmr_d   = '0;
            end
        endcase
    end

    always_comb begin
        for (int l = 0; l < NUM_LIGHTS; l++) begin
            lights_c[l] = RED;
            if (cur_mask[l] && state_q == TLC_GREEN)  lights_c[l] = GREEN;
            if (cur_mask[l] && state_q == TLC_YELLOW) lights_c[l] = YELLOW;
        end
    end

    assign bus.lights      = lights_c;
    assign bus.cur_phase   = phase_q;
    assign bus.tlc_state   = state_q;
    assign bus.preempt_ack = (state_q == TLC_GREEN) && pre_here;
endmodule

// File: tb/tb_tlc_multiphase.sv
// Testbench for tlc_multiphase: directed table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_tlc_multiphase;
    import light_package::*;

    localparam int NL = 5, NP = 5, VAC = 5, MAXG = 10, YEL = 2, ALR = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tlc_multiphase_if #(.NUM_LIGHTS(NL), .NUM_PHASES(NP)) bus ();

    tlc_multiphase #(
        .NUM_LIGHTS(NL), .NUM_PHASES(NP),
        .PHASE_MASK({5'b10000, 5'b01100, 5'b01010, 5'b00101, 5'b00011}),
        .VACANT_CYC(VAC), .MAX_GREEN_CYC(MAXG), .YELLOW_CYC(YEL), .ALLRED_CYC(ALR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [NL-1:0] tb_mask [NP];
    tlc_state_t    m_state;
    int            m_phase, m_left, m_vac, m_max;

    typedef struct {
        logic [NL-1:0] sensor;
        logic          preq;
        logic [2:0]    pp;
        tlc_state_t    st;
        int            ph;
        logic          ack;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = TLC_ALLRED;
        m_phase = NP - 1;
        m_left  = ALR;
        m_vac   = 0;
        m_max   = 0;
    endfunction

    function automatic bit m_pre_valid();
        return bus.preempt_req === 1'b1 && int'(bus.preempt_phase) < NP;
    endfunction

    // Behavioural model: counts elapsed cycles per rule, one call per clock edge.
    function automatic void model_step();
        logic [NL-1:0] s;
        bit pv, own, other;
        int pp;
        s     = bus.sensor;
        pv    = m_pre_valid();
        pp    = int'(bus.preempt_phase);
        own   = |(s & tb_mask[m_phase]);
        other = |(s & ~tb_mask[m_phase]);
        case (m_state)
            TLC_GREEN: begin
                if (pv && pp == m_phase) begin
                    m_vac = 0;
                    m_max = 0;
                end else if (pv) begin
                    m_state = TLC_YELLOW; m_left = YEL; m_vac = 0; m_max = 0;
                end else begin
                    if (m_vac > 0 || !own) m_vac++;
                    if (m_max > 0 || other) m_max++;
                    if (m_vac == VAC || m_max == MAXG) begin
                        m_state = TLC_YELLOW; m_left = YEL; m_vac = 0; m_max = 0;
                    end
                end
            end
            TLC_YELLOW: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = TLC_ALLRED;
                    m_left  = ALR;
                end
            end
            default: begin
                if (m_left > 1) m_left--;
                else if (pv) begin
                    m_state = TLC_GREEN; m_phase = pp; m_vac = 0; m_max = 0;
                end else begin
                    for (int k = 1; k <= NP; k++) begin
                        int q;
                        q = (m_phase + k) % NP;
                        if (|(s & tb_mask[q])) begin
                            m_state = TLC_GREEN; m_phase = q; m_vac = 0; m_max = 0;
                            break;
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic [2*NL-1:0] e;
        e = '0;
        for (int l = 0; l < NL; l++) begin
            if (tb_mask[m_phase][l] && m_state == TLC_GREEN)  e[2*l +: 2] = GREEN;
            if (tb_mask[m_phase][l] && m_state == TLC_YELLOW) e[2*l +: 2] = YELLOW;
        end
        check({tag, " lights"}, 32'(bus.lights), 32'(e));
        check({tag, " state"}, 32'(bus.tlc_state), 32'(m_state));
        check({tag, " phase"}, 32'(bus.cur_phase), 32'(m_phase));
        check({tag, " ack"}, 32'(bus.preempt_ack),
              32'(m_state == TLC_GREEN && m_pre_valid() && int'(bus.preempt_phase) == m_phase));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic add(input logic [NL-1:0] s, input logic pq, input logic [2:0] pp,
                       input tlc_state_t st, input int ph, input logic ack);
        vec_t v;
        v.sensor = s; v.preq = pq; v.pp = pp; v.st = st; v.ph = ph; v.ack = ack;
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        tb_mask = '{5'b00011, 5'b00101, 5'b01010, 5'b01100, 5'b10000};
        bus.sensor        = '0;
        bus.preempt_req   = 1'b0;
        bus.preempt_phase = '0;
        model_reset();

        // Reset held with idle and then busy sensors
        for (int i = 0; i < 50; i++) begin
            if (i == 25) bus.sensor = 5'b11111;
            tick("reset_hold");
            check("reset_phase4", 32'(bus.cur_phase), 32'd4);
        end

        // Directed vectors from the reset state (ALLRED, phase 4)
        add(5'b00001, 0, 0, TLC_GREEN,  0, 0);
        add(5'b00001, 0, 0, TLC_GREEN,  0, 0);
        add(5'b00001, 1, 4, TLC_YELLOW, 0, 0);
        add(5'b00001, 1, 4, TLC_YELLOW, 0, 0);
        add(5'b00001, 1, 4, TLC_ALLRED, 0, 0);
        add(5'b00000, 1, 4, TLC_GREEN,  4, 1);
        add(5'b00000, 1, 4, TLC_GREEN,  4, 1);
        add(5'b00000, 0, 4, TLC_GREEN,  4, 0);
        add(5'b00000, 0, 4, TLC_GREEN,  4, 0);
        add(5'b00000, 0, 4, TLC_GREEN,  4, 0);
        add(5'b00000, 0, 4, TLC_GREEN,  4, 0);
        add(5'b00000, 0, 4, TLC_YELLOW, 4, 0);
        add(5'b00000, 0, 4, TLC_YELLOW, 4, 0);
        add(5'b00000, 0, 4, TLC_ALLRED, 4, 0);
        add(5'b00000, 0, 4, TLC_ALLRED, 4, 0);
        add(5'b00100, 1, 7, TLC_GREEN,  1, 0);
        add(5'b00100, 0, 0, TLC_GREEN,  1, 0);
        add(5'b00000, 0, 0, TLC_GREEN,  1, 0);
        add(5'b00000, 0, 0, TLC_GREEN,  1, 0);
        add(5'b00000, 0, 0, TLC_GREEN,  1, 0);
        add(5'b00000, 0, 0, TLC_GREEN,  1, 0);
        add(5'b00000, 0, 0, TLC_YELLOW, 1, 0);
        add(5'b00000, 0, 0, TLC_YELLOW, 1, 0);
        add(5'b00000, 0, 0, TLC_ALLRED, 1, 0);
        add(5'b00010, 0, 0, TLC_GREEN,  2, 0);
        add(5'b00010, 0, 0, TLC_GREEN,  2, 0);
        add(5'b00010, 1, 7, TLC_GREEN,  2, 0);

        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) begin
            bus.sensor        = tbl[i].sensor;
            bus.preempt_req   = tbl[i].preq;
            bus.preempt_phase = tbl[i].pp;
            tick($sformatf("row%0d", i));
            check($sformatf("row%0d tbl_state", i), 32'(bus.tlc_state), 32'(tbl[i].st));
            check($sformatf("row%0d tbl_phase", i), 32'(bus.cur_phase), 32'(tbl[i].ph));
            check($sformatf("row%0d tbl_ack", i), 32'(bus.preempt_ack), 32'(tbl[i].ack));
        end

        // Max-green: conflict on phase 2 while its own demand stays present
        bus.preempt_req = 1'b0;
        bus.sensor      = 5'b10010;
        cnt = 0;
        do begin
            tick("maxg");
            cnt++;
        end while (bus.tlc_state == TLC_GREEN && cnt < 40);
        check("maxg_green_cycles", 32'(cnt), 32'(MAXG));
        bus.sensor = 5'b10000;
        cnt = 0;
        while (bus.tlc_state == TLC_YELLOW && cnt < 20) begin
            cnt++;
            tick("maxg_yel");
        end
        check("maxg_yellow_cycles", 32'(cnt), 32'(YEL));
        cnt = 0;
        while (bus.tlc_state == TLC_ALLRED && cnt < 20) begin
            cnt++;
            tick("maxg_ar");
        end
        check("maxg_allred_cycles", 32'(cnt), 32'(ALR));
        check("maxg_next_state", 32'(bus.tlc_state), 32'(TLC_GREEN));
        check("maxg_next_phase", 32'(bus.cur_phase), 32'd4);

        // Randomized traffic with occasional (sometimes out-of-range) preemption
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:       bus.sensor = '0;
                    2, 3, 4, 5: bus.sensor = NL'(1 << $urandom_range(0, NL - 1));
                    default:    bus.sensor = NL'($urandom);
                endcase
            end
            if ($urandom_range(0, 29) == 0) begin
                bus.preempt_req   = ~bus.preempt_req;
                bus.preempt_phase = 3'($urandom_range(0, 7));
            end
            tick("rand");
        end

        // Asynchronous reset in the middle of a yellow interval
        bus.preempt_req = 1'b0;
        reset = 1'b1;
        tick("rst2");
        reset = 1'b0;
        bus.sensor = 5'b00001;
        tick("rst2_green");
        bus.preempt_req   = 1'b1;
        bus.preempt_phase = 3'd4;
        tick("rst2_yellow");
        check("rst2_in_yellow", 32'(bus.tlc_state), 32'(TLC_YELLOW));
        #2;
        reset = 1'b1;
        #1;
        check("async_lights_red", 32'(bus.lights), 32'd0);
        check("async_state", 32'(bus.tlc_state), 32'(TLC_ALLRED));
        check("async_phase", 32'(bus.cur_phase), 32'd4);
        model_reset();
        bus.preempt_req = 1'b0;
        bus.sensor      = '0;
        for (int i = 0; i < 50; i++) tick("reset_hold2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tlc_multiphase.md
Name: tlc_multiphase

Overview:
- Parametrised N-phase successor of the 5-light, 20-state intersection controller. Same traffic-light domain and the same Moore-style green/yellow/all-red cycling.
- Phases are defined by a light mask instead of hard-coded states.
- Timing (vacant timeout, max-green, yellow, all-red) is set by parameters.
- Adds emergency preemption and debug/status outputs. Sits directly between the sensor inputs and the light drivers.

Parameters:
- NUM_LIGHTS, 5: number of light heads. Default order: 0 e_str, 1 w_str, 2 e_left, 3 w_left, 4 ns.
- NUM_PHASES, 5: number of phases (2..16).
- PHASE_MASK, {5'b10000, 5'b01100, 5'b01010, 5'b00101, 5'b00011}: NUM_PHASES*NUM_LIGHTS bits. Slice p is phase p's light set, with phase 0 in the LSBs.
- VACANT_CYC, 5: green cycles after own demand goes away (>=1).
- MAX_GREEN_CYC, 10: green cycles after conflicting demand appears (>=1).
- YELLOW_CYC, 2: yellow duration in cycles (>=1).
- ALLRED_CYC, 1: minimum all-red duration in cycles (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sensor  in  NUM_LIGHTS  per-light traffic present
- preempt_req  in  1  emergency preemption request (level)
- preempt_phase  in  $clog2(NUM_PHASES)  phase to serve under preemption
- lights  out  NUM_LIGHTS x colors  per-light colour (light_package colors)
- cur_phase  out  $clog2(NUM_PHASES)  phase currently or last served
- tlc_state  out  tlc_state_t  ALLRED / GREEN / YELLOW
- preempt_ack  out  1  preempt phase is green under an active request

Behaviour:
- Reset (async, immediate): state=ALLRED, cur_phase=NUM_PHASES-1, counters=0, all lights red, preempt_ack=0. Reset asserted mid-green or mid-yellow forces red in the same cycle, before any clock edge.
- Demand signals, per phase p:
  - dem[p] = |(sensor & mask[p]).
  - conf[p] = |(sensor & ~mask[p]).
- Preempt is valid when preempt_req=1 and preempt_phase<NUM_PHASES. Out-of-range preempt_phase is ignored.
- GREEN, phase p:
  - Lights in mask[p] are green; all others red.
  - vac_ctr increments when !dem[p] or vac_ctr!=0. Once started it continues even if demand returns.
  - max_ctr increments when conf[p] or max_ctr!=0.
  - Go to YELLOW when vac_ctr==VACANT_CYC-1 or max_ctr==MAX_GREEN_CYC-1; clear both counters.
  - Otherwise stay in GREEN.
- GREEN under valid preempt:
  - If p!=preempt_phase: go to YELLOW on the next edge and clear counters.
  - If p==preempt_phase: stay GREEN, hold counters at 0, preempt_ack=1. When the request drops, normal counting resumes from 0.
- YELLOW:
  - Lights in mask[p] are yellow.
  - Lasts exactly YELLOW_CYC cycles, then ALLRED. Preempt does not shorten it.
- ALLRED:
  - All lights red. Stay at least ALLRED_CYC cycles.
  - After the minimum, with valid preempt: go to GREEN of preempt_phase regardless of demand.
  - Otherwise, round-robin search starting at (p+1) mod N, then p+2, …, ending with p itself. The first phase with dem=1 goes GREEN and cur_phase is updated.
  - If no phase has demand, stay in ALLRED.
- Overlapping masks are legal (for example, e_str appears in phases 0 and 1). Colour is always derived from the current phase's mask only.
- Counter widths are $clog2(max(...)+1). Counters never wrap; they are compared with ==.
- Latency: a sensor sampled on edge k can produce green at the earliest at edge k+1, when in ALLRED past the minimum.

Decomposition:
- light_package gets:
  - tlc_state_t enum {TLC_ALLRED, TLC_GREEN, TLC_YELLOW}.
  - Default PHASE_MASK constant.
  - The existing colors enum is reused.
- One sub-module: tlc_rr_pick, a combinational round-robin first-set finder. Inputs: dem vector and last phase. Outputs: found and next phase.

Test Plan:
- Reset with no sensors → all lights red, tlc_state=ALLRED, cur_phase=4 for 50 cycles. Assert reset during YELLOW → lights red before the next edge.
- Release reset, sensor=5'b00001 held → after 1 all-red cycle, phase 0 green (lights 0,1 green) and held indefinitely.
- Phase 0 green with sensor 0 held, then sensor=5'b10001 → exactly 10 green cycles counted from the first conflict sample, 2 yellow, 1 all-red, then phase 4 green (ns).
- Phase 0 green, sensor drops to 0 → exactly 5 further green cycles (including the first low sample), yellow for 2, then ALLRED held.
- Phase 0 green, preempt_req=1, preempt_phase=4 → yellow on the next edge, 2 yellow, 1 all-red, then ns green with preempt_ack=1 held for 30 cycles. Drop the request with no sensors → ns yellow 5 cycles later.
- After phase 1 served, enter ALLRED with dem for phases 0 and 3 → phase 3 chosen (search starts at 2). Repeat with preempt_phase=7 → request ignored.
